tone_sequencer: RTL and testbench
=================================

# tone_sequencer

Parametrised tone sequencer that plays a note list from an external synchronous ROM on a single buzzer output, with start/stop control, per-note duration and an inter-note gap. It adds optional looping and a completion pulse. Period lookup is external combinational logic (note index in, period out). It sits between the board-level buzzer pin and the note ROM / period table.

## Interface
- `ADDR_W`, 9: ROM address width.
- `NOTE_W`, 5: note index width. Index 0 is a rest.
- `DUR_W`, 3: per-note duration field width, in beats.
- `PER_W`, 20: tone period width, in clk cycles.
- `MUSIC_LEN`, 136: number of steps, 1..2^ADDR_W.
- `BEAT_CYCLES`, 12_500_000: clk cycles per beat, ≥1.
- `GAP_CYCLES`, 1_250_000: silent cycles after each note, ≥0.
- `DUTY_SHIFT`, 6: low-time = period >> DUTY_SHIFT (volume).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level; sampled only in IDLE.
- `stop` in 1: level; abort from any state.
- `loop_en` in 1: sampled at end of the last step.
- `rom_addr` out ADDR_W: step address.
- `rom_data` in NOTE_W+DUR_W: {dur, note}; valid 1 cycle after `rom_addr`.
- `note_sel` out NOTE_W: latched note index to the period table.
- `note_period` in PER_W: combinational period for `note_sel`.
- `buzzer` out 1: registered, active-low drive.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse on natural completion.
- `step_idx` out ADDR_W: equals `rom_addr`.

## Operation
- Reset: state IDLE, `buzzer`=1, `busy`=0, `done`=0, `rom_addr`=0, `note_sel`=0, all counters 0.
- States: IDLE, FETCH_A, FETCH_B, PLAY, GAP.
- IDLE: if `start` && !`stop`, go to FETCH_A with `rom_addr` unchanged (0).
- FETCH_A: ROM captures the address. Go to FETCH_B.
- FETCH_B: latch `note_sel` ← rom_data[NOTE_W-1:0] and duration ← rom_data[high]. A duration of 0 is treated as 1. Go to PLAY.
- PLAY: beat counter runs 0..BEAT_CYCLES-1. Duration counter increments on each beat wrap. After dur×BEAT_CYCLES cycles, go to GAP, or directly to the step-advance decision if GAP_CYCLES=0.
- GAP: GAP_CYCLES cycles. `buzzer`=1 and the tone counter is held at 0.
- Step advance, when leaving GAP:
  - If `rom_addr` < MUSIC_LEN-1: `rom_addr`+1, go to FETCH_A.
  - Else if `loop_en`: `rom_addr`←0, go to FETCH_A.
  - Else: `done`=1 for one cycle, `rom_addr`←0, go to IDLE.
- Tone in PLAY:
  - hz_cnt counts 0..note_period-1 and wraps. It restarts at 0 on PLAY entry.
  - `buzzer`=0 when hz_cnt < (note_period >> DUTY_SHIFT), else 1.
  - Forced `buzzer`=1 when note_sel=0, note_period=0, or note_period>>DUTY_SHIFT = 0.
- `stop` high in any non-IDLE state: next state IDLE, `buzzer`=1, `rom_addr`←0, `done` not asserted. `stop` beats both completion and `start` in the same cycle.
- `start` while `busy` is ignored. `start` held high after `done` restarts the song from step 0 on the next cycle.
- Arithmetic: all counters unsigned. The beat counter width is sized for BEAT_CYCLES. The duration counter is DUR_W bits. No counter overflows for any legal parameter set.

## Timing
- `start` sampled at edge E0 → `busy`=1 after E0.
- PLAY entered after E2. The first possible `buzzer`=0 is after E3, since `buzzer` is registered.
- Step length = 2 + dur×BEAT_CYCLES + GAP_CYCLES cycles, where dur is the clamped value.
- `done` is high exactly one cycle, concurrent with state returning to IDLE. `busy` falls on the same edge.
- `stop` takes effect on the next edge.
- `note_sel` stays stable from FETCH_B through the end of GAP.

## Test plan
Parameters for all scenarios: MUSIC_LEN=3, BEAT_CYCLES=10, GAP_CYCLES=2, DUTY_SHIFT=1. ROM = {dur1,note3}, {dur2,note0}, {dur0,note5}. Periods: note3→4, note5→6.

- **Single run.** Stimulus: start pulse, loop_en=0. Required:
  - Step lengths 14, 24 and 14 cycles.
  - `done` pulses once, 52 cycles after the start edge, then `busy`=0.
- **Tone shape.** Step 0 PLAY: `buzzer` pattern 0,0,1,1 repeating (period 4, low 2). Step 1, the rest: `buzzer` constant 1.
- **Zero duration.** Step 2 (dur 0) plays exactly 10 cycles with pattern 0,0,0,1,1,1.
- **Loop.** loop_en=1: after step 2, `rom_addr` returns to 0 and FETCH_A follows; `done` never pulses. Drop loop_en during the second pass: `done` pulses at the end of that pass.
- **Abort.** `stop` asserted mid-step 1: the next cycle shows IDLE, `buzzer`=1, `rom_addr`=0, no `done`. `stop` and completion in the same cycle: no `done`.
- **Reset and start guard.**
  - `rst` mid-PLAY: all outputs return to their reset values on the next edge.
  - `start` pulses while busy: no change in the step sequence.

Source files
------------

// File: rtl/tone_sequencer.sv
// Tone sequencer: walks an external note ROM and drives an active-low buzzer with a
// per-note square wave, a per-note duration in beats and a silent gap after each note.
module tone_sequencer #(
    parameter int ADDR_W      = 9,
    parameter int NOTE_W      = 5,
    parameter int DUR_W       = 3,
    parameter int PER_W       = 20,
    parameter int MUSIC_LEN   = 136,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000,
    parameter int DUTY_SHIFT  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note_sel,
    input  logic [PER_W-1:0]        note_period,
    output logic                    buzzer,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       step_idx
);

    localparam int BEAT_W = $clog2(BEAT_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 2);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(MUSIC_LEN - 1);

    // state   | meaning
    // IDLE    | silent, waiting for start
    // FETCH_A | ROM registers rom_addr
    // FETCH_B | note and duration latched from rom_data
    // PLAY    | tone for dur beats
    // GAP     | silent gap, then step advance
    typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, PLAY, GAP} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic [NOTE_W-1:0]    note_sel_q, note_sel_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic [DUR_W-1:0]     dur_cnt_q, dur_cnt_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [PER_W-1:0]     hz_cnt_q, hz_cnt_d;
    logic                 buzzer_q, buzzer_d;
    logic                 done_q, done_d;

    logic [PER_W-1:0]     low_time;
    logic [PER_W:0]       hz_next;
    logic [DUR_W-1:0]     rom_dur;
    logic                 tone_on;
    logic                 play_end;
    logic                 gap_end;
    logic                 advance;

    assign low_time = note_period >> DUTY_SHIFT;
    assign hz_next  = {1'b0, hz_cnt_q} + (PER_W+1)'(1);
    assign rom_dur  = rom_data[NOTE_W+DUR_W-1:NOTE_W];
    assign tone_on  = (note_sel_q != '0) && (note_period != '0) && (low_time != '0)
                      && (hz_cnt_q < low_time);
    assign play_end = (beat_cnt_q == BEAT_LAST) && (dur_cnt_q == dur_q - DUR_W'(1));
    assign gap_end  = (gap_cnt_q == GAP_LAST);

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        note_sel_d = note_sel_q;
        dur_d      = dur_q;
        dur_cnt_d  = '0;
        beat_cnt_d = '0;
        gap_cnt_d  = '0;
        hz_cnt_d   = '0;
        buzzer_d   = 1'b1;
        done_d     = 1'b0;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) state_d = FETCH_A;
            end
            FETCH_A: state_d = FETCH_B;
            FETCH_B: begin
                note_sel_d = rom_data[NOTE_W-1:0];
                dur_d      = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
                state_d    = PLAY;
            end
            PLAY: begin
                buzzer_d = !tone_on;
                hz_cnt_d = (hz_next >= {1'b0, note_period}) ? '0 : hz_next[PER_W-1:0];
                if (beat_cnt_q == BEAT_LAST) begin
                    beat_cnt_d = '0;
                    dur_cnt_d  = dur_cnt_q + DUR_W'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    dur_cnt_d  = dur_cnt_q;
                end
                if (play_end) begin
                    beat_cnt_d = '0;
                    dur_cnt_d  = '0;
                    hz_cnt_d   = '0;
                    if (GAP_CYCLES == 0) advance = 1'b1;
                    else                 state_d = GAP;
                end
            end
            GAP: begin
                if (gap_end) advance = 1'b1;
                else         gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (rom_addr_q < LAST_STEP) begin
                rom_addr_d = rom_addr_q + ADDR_W'(1);
                state_d    = FETCH_A;
            end else if (loop_en) begin
                rom_addr_d = '0;
                state_d    = FETCH_A;
            end else begin
                rom_addr_d = '0;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
        end

        // Abort wins over completion and over anything the step logic decided.
        if (stop && (state_q != IDLE)) begin
            state_d    = IDLE;
            rom_addr_d = '0;
            done_d     = 1'b0;
            buzzer_d   = 1'b1;
            dur_cnt_d  = '0;
            beat_cnt_d = '0;
            gap_cnt_d  = '0;
            hz_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            note_sel_q <= '0;
            dur_q      <= '0;
            dur_cnt_q  <= '0;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
            hz_cnt_q   <= '0;
            buzzer_q   <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            note_sel_q <= note_sel_d;
            dur_q      <= dur_d;
            dur_cnt_q  <= dur_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            hz_cnt_q   <= hz_cnt_d;
            buzzer_q   <= buzzer_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign step_idx = rom_addr_q;
    assign note_sel = note_sel_q;
    assign buzzer   = buzzer_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: a per-cycle song model built from the note list drives
// expected address, busy, done, note and buzzer traces.
module tb_tone_sequencer;

    localparam int ADDR_W    = 9;
    localparam int NOTE_W    = 5;
    localparam int DUR_W     = 3;
    localparam int PER_W     = 20;
    localparam int MUSIC_LEN = 3;
    localparam int BEAT      = 10;
    localparam int GAP       = 2;
    localparam int DUTY      = 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    stop;
    logic                    loop_en;
    logic [ADDR_W-1:0]       rom_addr;
    logic [ADDR_W-1:0]       step_idx;
    logic [NOTE_W+DUR_W-1:0] rom_data;
    logic [NOTE_W-1:0]       note_sel;
    logic [PER_W-1:0]        note_period;
    logic                    buzzer;
    logic                    busy;
    logic                    done;

    logic [7:0]       rom_m   [0:3];
    logic [PER_W-1:0] per_tab [0:31];

    int vectors     = 0;
    int miscompares = 0;

    int exp_addr[$];
    bit exp_intent[$];
    bit exp_busy[$];
    bit exp_done[$];
    int exp_note[$];
    bit drv_start[$];
    bit drv_loop[$];

    int first_k [0:MUSIC_LEN-1];
    int addr_log [0:1023];
    bit buz_log  [0:1023];
    int done_k;
    int done_pulses;

    tone_sequencer #(
        .ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .PER_W(PER_W),
        .MUSIC_LEN(MUSIC_LEN), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .DUTY_SHIFT(DUTY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .note_sel(note_sel),
        .note_period(note_period), .buzzer(buzzer), .busy(busy), .done(done),
        .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom_m[rom_addr[1:0]];
    assign note_period = per_tab[note_sel];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_plan();
        for (int i = 0; i < 32; i++) per_tab[i] = '0;
        per_tab[3] = 20'd4;
        per_tab[5] = 20'd6;
        rom_m[0] = {3'd1, 5'd3};
        rom_m[1] = {3'd2, 5'd0};
        rom_m[2] = {3'd0, 5'd5};
        rom_m[3] = 8'h00;
    endtask

    task automatic clear_model();
        exp_addr.delete(); exp_intent.delete(); exp_busy.delete();
        exp_done.delete(); exp_note.delete(); drv_start.delete(); drv_loop.delete();
        for (int i = 0; i < MUSIC_LEN; i++) first_k[i] = -1;
        done_k = -1;
        done_pulses = 0;
    endtask

    task automatic push_cycle(input int a, input bit intent, input bit bsy, input bit dn,
                              input int nt);
        exp_addr.push_back(a);
        exp_intent.push_back(intent);
        exp_busy.push_back(bsy);
        exp_done.push_back(dn);
        exp_note.push_back(nt);
    endtask

    // One pass over the note list: two fetch cycles, dur*BEAT tone cycles, GAP silent cycles.
    task automatic model_pass();
        for (int s = 0; s < MUSIC_LEN; s++) begin
            int d, nt, per, low, dur;
            bit silent, lvl;
            d   = int'(rom_m[s][7:5]);
            nt  = int'(rom_m[s][4:0]);
            dur = (d == 0) ? 1 : d;
            per = int'(per_tab[nt]);
            low = per >> DUTY;
            silent = (nt == 0) || (per == 0) || (low == 0);
            push_cycle(s, 1'b1, 1'b1, 1'b0, -1);
            push_cycle(s, 1'b1, 1'b1, 1'b0, -1);
            for (int i = 0; i < dur * BEAT; i++) begin
                lvl = silent ? 1'b1 : (((i % per) < low) ? 1'b0 : 1'b1);
                push_cycle(s, lvl, 1'b1, 1'b0, nt);
            end
            for (int i = 0; i < GAP; i++) push_cycle(s, 1'b1, 1'b1, 1'b0, nt);
        end
    endtask

    task automatic model_end();
        push_cycle(0, 1'b1, 1'b0, 1'b1, -1);
    endtask

    task automatic model_idle(input int n);
        for (int i = 0; i < n; i++) push_cycle(0, 1'b1, 1'b0, 1'b0, -1);
    endtask

    // Drive start/loop_en per cycle and compare every output against the model trace.
    task automatic run_model(input string tag);
        int n, a;
        bit eb;
        n = exp_addr.size();
        for (int k = 0; k < n; k++) begin
            start   = drv_start[k];
            loop_en = drv_loop[k];
            tick();
            eb = (k == 0) ? 1'b1 : exp_intent[k-1];
            a  = int'(rom_addr);
            if (k < 1024) begin
                addr_log[k] = a;
                buz_log[k]  = buzzer;
            end
            if (done === 1'b1) begin
                done_pulses++;
                if (done_k < 0) done_k = k;
            end
            if (busy === 1'b1 && a < MUSIC_LEN && first_k[a] < 0) first_k[a] = k;

            vectors++;
            if (rom_addr !== ADDR_W'(exp_addr[k])) begin
                miscompares++;
                $display("FAIL %s rom_addr k=%0d got %0d exp %0d", tag, k, rom_addr, exp_addr[k]);
            end
            vectors++;
            if (step_idx !== ADDR_W'(exp_addr[k])) begin
                miscompares++;
                $display("FAIL %s step_idx k=%0d got %0d exp %0d", tag, k, step_idx, exp_addr[k]);
            end
            vectors++;
            if (busy !== exp_busy[k]) begin
                miscompares++;
                $display("FAIL %s busy k=%0d got %b exp %b", tag, k, busy, exp_busy[k]);
            end
            vectors++;
            if (done !== exp_done[k]) begin
                miscompares++;
                $display("FAIL %s done k=%0d got %b exp %b", tag, k, done, exp_done[k]);
            end
            vectors++;
            if (buzzer !== eb) begin
                miscompares++;
                $display("FAIL %s buzzer k=%0d got %b exp %b", tag, k, buzzer, eb);
            end
            if (exp_note[k] >= 0) begin
                vectors++;
                if (note_sel !== NOTE_W'(exp_note[k])) begin
                    miscompares++;
                    $display("FAIL %s note_sel k=%0d got %0d exp %0d", tag, k, note_sel, exp_note[k]);
                end
            end
        end
        start   = 1'b0;
        loop_en = 1'b0;
    endtask

    task automatic plain_song(input string tag);
        load_plan();
        clear_model();
        model_pass();
        model_end();
        model_idle(3);
        for (int k = 0; k < exp_addr.size(); k++) begin
            drv_start.push_back(k == 0);
            drv_loop.push_back(1'b0);
        end
        run_model(tag);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        load_plan();
        tick(); tick();
        vectors++;
        if (buzzer !== 1'b1) begin miscompares++; $display("FAIL reset buzzer got %b exp 1", buzzer); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b exp 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset done got %b exp 0", done); end
        vectors++;
        if (rom_addr !== '0) begin miscompares++; $display("FAIL reset rom_addr got %0d exp 0", rom_addr); end
        vectors++;
        if (note_sel !== '0) begin miscompares++; $display("FAIL reset note_sel got %0d exp 0", note_sel); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_run();
        plain_song("single");
        vectors++;
        if (first_k[1] - first_k[0] != 14) begin
            miscompares++; $display("FAIL step0_len got %0d exp 14", first_k[1] - first_k[0]);
        end
        vectors++;
        if (first_k[2] - first_k[1] != 24) begin
            miscompares++; $display("FAIL step1_len got %0d exp 24", first_k[2] - first_k[1]);
        end
        vectors++;
        if (done_k - first_k[2] != 14) begin
            miscompares++; $display("FAIL step2_len got %0d exp 14", done_k - first_k[2]);
        end
        vectors++;
        if (done_k != 52 || done_pulses != 1) begin
            miscompares++; $display("FAIL done_time got k=%0d pulses=%0d exp k=52 pulses=1", done_k, done_pulses);
        end
    endtask

    task automatic test_tone_shape();
        bit e;
        plain_song("tone");
        // Step 0 tone cycles 2..11 are seen on buzzer at samples 3..12.
        for (int i = 0; i < 10; i++) begin
            e = ((i % 4) < 2) ? 1'b0 : 1'b1;
            vectors++;
            if (buz_log[i+3] !== e) begin
                miscompares++; $display("FAIL tone_step0 i=%0d got %b exp %b", i, buz_log[i+3], e);
            end
        end
        for (int k = 14; k < 38; k++) begin
            vectors++;
            if (buz_log[k] !== 1'b1) begin
                miscompares++; $display("FAIL rest_step1 k=%0d got %b exp 1", k, buz_log[k]);
            end
        end
    endtask

    task automatic test_zero_duration();
        bit e;
        plain_song("zerodur");
        for (int i = 0; i < 10; i++) begin
            e = ((i % 6) < 3) ? 1'b0 : 1'b1;
            vectors++;
            if (buz_log[i+41] !== e || addr_log[i+41] != 2) begin
                miscompares++;
                $display("FAIL zerodur i=%0d got %b addr %0d exp %b addr 2", i, buz_log[i+41], addr_log[i+41], e);
            end
        end
        vectors++;
        if (buz_log[51] !== 1'b1 || addr_log[51] != 2) begin
            miscompares++; $display("FAIL zerodur_gap got %b addr %0d exp 1 addr 2", buz_log[51], addr_log[51]);
        end
    endtask

    task automatic test_loop();
        load_plan();
        clear_model();
        model_pass();
        model_pass();
        model_end();
        model_idle(3);
        for (int k = 0; k < exp_addr.size(); k++) begin
            drv_start.push_back(k == 0);
            drv_loop.push_back(k <= 60);
        end
        run_model("loop");
        vectors++;
        if (addr_log[51] != 2 || addr_log[52] != 0) begin
            miscompares++; $display("FAIL loop_wrap got %0d,%0d exp 2,0", addr_log[51], addr_log[52]);
        end
        vectors++;
        if (done_pulses != 1 || done_k != 104) begin
            miscompares++; $display("FAIL loop_done got k=%0d pulses=%0d exp k=104 pulses=1", done_k, done_pulses);
        end
    endtask

    task automatic test_abort();
        load_plan();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) tick();
        vectors++;
        if (rom_addr !== 9'd1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL abort_pre got addr %0d busy %b exp 1 1", rom_addr, busy);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        vectors++;
        if (busy !== 1'b0 || buzzer !== 1'b1 || rom_addr !== '0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_mid got busy %b buz %b addr %0d done %b exp 0 1 0 0", busy, buzzer, rom_addr, done);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL abort_after got busy %b done %b exp 0 0", busy, done);
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 51; k++) tick();
        vectors++;
        if (rom_addr !== 9'd2 || busy !== 1'b1) begin
            miscompares++; $display("FAIL abort_end_pre got addr %0d busy %b exp 2 1", rom_addr, busy);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || rom_addr !== '0) begin
            miscompares++; $display("FAIL abort_end got done %b busy %b addr %0d exp 0 0 0", done, busy, rom_addr);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++; $display("FAIL abort_end_late got done %b exp 0", done);
        end

        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL stop_beats_start got busy %b exp 0", busy);
        end
    endtask

    task automatic test_reset_mid_play();
        load_plan();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        vectors++;
        if (note_sel !== 5'd3 || busy !== 1'b1) begin
            miscompares++; $display("FAIL rst_pre got note %0d busy %b exp 3 1", note_sel, busy);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (buzzer !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== '0
            || note_sel !== '0 || step_idx !== '0) begin
            miscompares++;
            $display("FAIL rst_mid got buz %b busy %b done %b addr %0d note %0d exp 1 0 0 0 0",
                     buzzer, busy, done, rom_addr, note_sel);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_start_guard();
        load_plan();
        clear_model();
        model_pass();
        model_end();
        model_idle(3);
        for (int k = 0; k < exp_addr.size(); k++) begin
            if (k == 0) drv_start.push_back(1'b1);
            else        drv_start.push_back(exp_busy[k-1] ? 1'($urandom_range(0, 1)) : 1'b0);
            drv_loop.push_back(1'b0);
        end
        run_model("guard");
        vectors++;
        if (done_k != 52) begin
            miscompares++; $display("FAIL guard_done got k=%0d exp 52", done_k);
        end
    endtask

    task automatic test_back_to_back();
        load_plan();
        clear_model();
        model_pass();
        model_end();
        model_pass();
        model_end();
        model_idle(3);
        for (int k = 0; k < exp_addr.size(); k++) begin
            drv_start.push_back(k <= 60);
            drv_loop.push_back(1'b0);
        end
        run_model("b2b");
        vectors++;
        if (done_pulses != 2) begin
            miscompares++; $display("FAIL b2b_done got %0d pulses exp 2", done_pulses);
        end
    endtask

    task automatic test_random();
        int passes, l1;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 32; i++) per_tab[i] = PER_W'($urandom_range(0, 9));
            for (int i = 0; i < MUSIC_LEN; i++) rom_m[i] = 8'($urandom_range(0, 255));
            rom_m[3] = 8'h00;
            passes = int'($urandom_range(1, 2));
            clear_model();
            model_pass();
            l1 = exp_addr.size();
            if (passes == 2) model_pass();
            model_end();
            model_idle(2);
            for (int k = 0; k < exp_addr.size(); k++) begin
                if (k == 0) drv_start.push_back(1'b1);
                else        drv_start.push_back(exp_busy[k-1] ? 1'($urandom_range(0, 1)) : 1'b0);
                drv_loop.push_back((passes == 2) && (k <= l1 + 3));
            end
            run_model("random");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        test_reset();
        test_single_run();
        test_tone_shape();
        test_zero_duration();
        test_loop();
        test_abort();
        test_reset_mid_play();
        test_start_guard();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
